// File: rtl/pcm_interp_feeder.sv
// Purpose: buffers upstream PCM samples and feeds one W-bit sample per clk to the DAC, interpolating between samples.
// Latency: pcm_out is registered, one cycle after phase/prev/cur; first input pops the cycle after it lands in the FIFO.
// Backpressure: s_ready = !full; one sample is consumed every 2**RATIO_LOG2 clocks. Macro LINEAR_INTERP_EN selects linear interpolation (else zero-order hold).

// Small synchronous FIFO with occupancy count; no push-to-pop bypass.
module pcm_interp_feeder_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [W-1:0]             i_push_dat,
  input  logic                     i_pop,
  output logic [W-1:0]             o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;

  // Storage array; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Occupancy: simultaneous push and pop leave the level unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_level <= '0;
    end else begin
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_level == LVL_W'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
endmodule

module pcm_interp_feeder #(
  parameter int W          = 16,
  parameter int DEPTH      = 4,
  parameter int RATIO_LOG2 = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  input  logic [W-1:0]           s_data,
  output logic                   s_ready,
  output logic [W-1:0]           pcm_out,
  output logic                   underrun,
  output logic [$clog2(DEPTH):0] fifo_level
);
  localparam logic [RATIO_LOG2-1:0] PH_LAST = '1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [RATIO_LOG2-1:0] r_phase;
  logic [W-1:0]          r_cur;
  logic [W-1:0]          w_head;
  logic [W-1:0]          w_pcm_nxt;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_start;
  logic                  w_pop_point;
  logic                  w_underrun;

  assign w_push  = s_valid && !w_full;
  assign s_ready = !w_full;

  pcm_interp_feeder_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_push_dat (s_data),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_level    (fifo_level)
  );

  // State register: once running, only reset returns to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and pop decisions: start on first data, then pop once per output period.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_start     = 1'b0;
    w_pop_point = 1'b0;
    w_underrun  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = S_RUN;
          w_start     = 1'b1;
          w_pop       = 1'b1;
        end
      end
      S_RUN: begin
        if (r_phase == PH_LAST) begin
          w_pop_point = 1'b1;
          if (!w_empty) w_pop      = 1'b1;
          else          w_underrun = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign underrun = w_underrun;

  // Phase counter runs freely while RUN and sits at zero otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_phase <= '0;
    else if (w_start)           r_phase <= '0;
    else if (r_state == S_RUN)  r_phase <= r_phase + 1'b1;
    else                        r_phase <= '0;
  end

  // Current sample: replaced on every pop, held through underruns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_cur <= '0;
    else if (w_pop) r_cur <= w_head;
  end

`ifdef LINEAR_INTERP_EN
  localparam int PW = W + RATIO_LOG2 + 1;

  logic [W-1:0]        r_prev;
  logic signed [W:0]   w_diff;
  logic signed [PW-1:0] w_prod;

  // Previous sample: starts from silence, then takes the outgoing cur at each pop point.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            r_prev <= '0;
    else if (w_start)     r_prev <= '0;
    else if (w_pop_point) r_prev <= r_cur;
  end

  // prev + floor((cur - prev) * phase / 2**RATIO_LOG2); the result stays within [prev, cur].
  assign w_diff    = $signed({r_cur[W-1], r_cur}) - $signed({r_prev[W-1], r_prev});
  assign w_prod    = PW'(w_diff) * PW'($signed({1'b0, r_phase}));
  assign w_pcm_nxt = W'($signed({{(RATIO_LOG2 + 1){r_prev[W-1]}}, r_prev}) + (w_prod >>> RATIO_LOG2));
`else
  // Zero-order hold: the output simply follows the current sample.
  assign w_pcm_nxt = r_cur;
`endif

  // Output register: silent in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  pcm_out <= '0;
    else if (r_state == S_IDLE) pcm_out <= '0;
    else                        pcm_out <= w_pcm_nxt;
  end
endmodule

// File: tb/tb_pcm_interp_feeder.sv
// Bench for pcm_interp_feeder (W=16, DEPTH=4, RATIO_LOG2=2): directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model through an expectation scoreboard.
// Inputs change at posedge+1; the model samples at negedge, the monitor compares at negedge+1.
module tb_pcm_interp_feeder;
  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int RL    = 2;
  localparam int N     = 1 << RL;
`ifdef LINEAR_INTERP_EN
  localparam bit LIN = 1'b1;
`else
  localparam bit LIN = 1'b0;
`endif

  logic          clk     = 1'b0;
  logic          reset   = 1'b1;
  logic          s_valid = 1'b0;
  logic [W-1:0]  s_data  = '0;
  logic          s_ready;
  logic [W-1:0]  pcm_out;
  logic          underrun;
  logic [2:0]    fifo_level;

  pcm_interp_feeder #(
    .W          (W),
    .DEPTH      (DEPTH),
    .RATIO_LOG2 (RL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .pcm_out    (pcm_out),
    .underrun   (underrun),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] pcm;
    logic         ur;
    logic [2:0]   lvl;
    logic         rdy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  int          m_q[$];
  bit          m_run  = 1'b0;
  int          m_ph   = 0;
  int          m_prev = 0;
  int          m_cur  = 0;
  logic [W-1:0] m_pcm = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, expv);
    end
  endtask

  // Output rule: interpolate with floor division, or hold the current sample.
  function automatic logic [W-1:0] f_out(input int p, input int c, input int ph);
    int d;
    int q;
    d = (c - p) * ph;
    q = d / N;
    if (d < 0 && (d % N) != 0) q = q - 1;
    return LIN ? W'(p + q) : W'(c);
  endfunction

  // Reference model: predicts this cycle's outputs, then applies the coming clock edge.
  initial begin
    forever begin
      exp_t         e;
      bit           acc;
      logic [W-1:0] nxt_pcm;
      @(negedge clk);
      if (reset) begin
        m_q.delete();
        m_run  = 1'b0;
        m_ph   = 0;
        m_prev = 0;
        m_cur  = 0;
        m_pcm  = '0;
        e.pcm = '0; e.ur = 1'b0; e.lvl = 3'd0; e.rdy = 1'b1;
        exp_q.push_back(e);
      end else begin
        e.pcm = m_pcm;
        e.lvl = 3'(m_q.size());
        e.rdy = (m_q.size() < DEPTH);
        e.ur  = m_run && (m_ph == N - 1) && (m_q.size() == 0);
        exp_q.push_back(e);
        acc     = s_valid && e.rdy;
        nxt_pcm = m_run ? f_out(m_prev, m_cur, m_ph) : '0;
        if (!m_run) begin
          if (m_q.size() > 0) begin
            m_cur  = m_q.pop_front();
            m_prev = 0;
            m_ph   = 0;
            m_run  = 1'b1;
          end
        end else begin
          if (m_ph == N - 1) begin
            m_prev = m_cur;
            if (m_q.size() > 0) m_cur = m_q.pop_front();
          end
          m_ph = (m_ph + 1) % N;
        end
        if (acc) m_q.push_back(int'($signed(s_data)));
        m_pcm = nxt_pcm;
      end
    end
  end

  // Monitor: compares every cycle's outputs against the oldest expectation.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pcm_out",    32'(pcm_out),    32'(e.pcm));
        chk("underrun",   32'(underrun),   32'(e.ur));
        chk("fifo_level", 32'(fifo_level), 32'(e.lvl));
        chk("s_ready",    32'(s_ready),    32'(e.rdy));
      end
    end
  end

  // Offer one sample and hold it until accepted; starts and ends at posedge+1.
  task automatic send(input logic [W-1:0] d);
    bit acc;
    acc     = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    s_valid = 1'b0;
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    bit found;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    #2;
    chk("rst_pcm",   32'(pcm_out),    32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ready", 32'(s_ready),    32'd1);
    chk("rst_ur",    32'(underrun),   32'd0);
    @(posedge clk);
    #1;

    // five samples back to back from IDLE, then drain into underrun
    for (int i = 0; i < 5; i++) send(W'(16'h1000 * (i + 1)));
    idle(40);
    do_reset();

    // ramp 0x0000 -> 0x0400
    send(16'h0000);
    send(16'h0400);
    idle(24);
    do_reset();

    // negative slope rounding: 1 -> -1
    send(16'h0001);
    send(16'hFFFF);
    idle(24);
    do_reset();

    // single sample then starvation
    send(16'h1234);
    idle(32);
    do_reset();

    // full-scale step
    send(16'h7FFF);
    send(16'h8000);
    idle(24);
    do_reset();

    // reset mid-RUN with three samples buffered
    found   = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'h5A5A;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      #2;
      if (m_run && m_q.size() == 3) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      s_data = W'($urandom);
    end
    chk("midrun_reach", 32'(found), 32'd1);
    @(posedge clk);
    #1 s_valid = 1'b0;
    chk("midrun_level_before", 32'(fifo_level), 32'd3);
    #1 reset = 1'b1;
    #1;
    chk("midrun_pcm",   32'(pcm_out),    32'd0);
    chk("midrun_level", 32'(fifo_level), 32'd0);
    chk("midrun_ready", 32'(s_ready),    32'd1);
    chk("midrun_ur",    32'(underrun),   32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // random traffic mixing backpressure and underruns
    for (int k = 0; k < 300; k++) begin
      idle($urandom_range(0, 5));
      send(W'($urandom));
    end
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
